bitstream_expander: RTL and testbench

BITSTREAM_EXPANDER -- requirements
Module: bitstream_expander

---
 rtl/bitstream_expander_pkg.sv | 24 ++
 rtl/bitstream_expander_if.sv | 30 +++
 rtl/bitstream_fifo.sv | 81 ++++++++
 rtl/bitstream_expander.sv | 181 ++++++++++++++++++
 tb/tb_bitstream_expander.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bitstream_expander_pkg.sv
// Shared flag codes and FSM state encoding for the bitstream expander.
package bitstream_expander_pkg;

  localparam logic [2:0] FLAG_NONE    = 3'd0;
  localparam logic [2:0] FLAG_ILLEGAL = 3'd4;
  localparam logic [2:0] FLAG_RUN     = 3'd5;
  localparam logic [2:0] FLAG_RUN_B4  = 3'd6;
  localparam logic [2:0] FLAG_RUN_B5  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEAD   = 3'd1,
    ST_DIRECT = 3'd2,
    ST_RUN    = 3'd3,
    ST_TAIL4  = 3'd4,
    ST_TAIL5  = 3'd5
  } state_e;

  // True for every code that puts at least one byte into the FIFO.
  function automatic logic flag_emits(input logic [2:0] flag);
    return (flag != FLAG_NONE) && (flag != FLAG_ILLEGAL);
  endfunction

endpackage

// File: rtl/bitstream_expander_if.sv
// Packet input and byte-stream output handshakes of the bitstream expander.
interface bitstream_expander_if #(
  parameter int BS_WIDTH = 8
) ();
  logic                in_valid;
  logic                in_ready;
  logic [BS_WIDTH-1:0] in_bit_1;
  logic [BS_WIDTH-1:0] in_bit_2;
  logic [BS_WIDTH-1:0] in_bit_3;
  logic [BS_WIDTH-1:0] in_bit_4;
  logic [BS_WIDTH-1:0] in_bit_5;
  logic [2:0]          in_flag_bitstream;
  logic                in_flag_last;
  logic [BS_WIDTH-1:0] out_byte;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;

  modport master (
    output in_valid, in_bit_1, in_bit_2, in_bit_3, in_bit_4, in_bit_5,
    output in_flag_bitstream, in_flag_last, out_ready,
    input  in_ready, out_byte, out_valid, out_last
  );

  modport slave (
    input  in_valid, in_bit_1, in_bit_2, in_bit_3, in_bit_4, in_bit_5,
    input  in_flag_bitstream, in_flag_last, out_ready,
    output in_ready, out_byte, out_valid, out_last
  );
endinterface

// File: rtl/bitstream_fifo.sv
// Output FIFO with a registered head stage; can set the tag (MSB) of its newest entry.
module bitstream_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             retag,
  output logic             pending,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  input  logic             pop_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, newest_ptr;
  logic [AW:0]      count_reg;
  logic [WIDTH-1:0] newest_reg, head_reg;
  logic             head_valid_reg;
  logic             do_push, mem_pop, retag_mem;

  assign full       = (count_reg == (AW+1)'(DEPTH));
  assign do_push    = push && !full;
  assign mem_pop    = (count_reg != '0) && (!head_valid_reg || pop_ready);
  assign retag_mem  = retag && (count_reg != '0);
  assign newest_ptr = wr_ptr_reg - PTR_ONE;
  // Entry survives this edge if it is still in memory or held at the head.
  assign pending    = (count_reg != '0) || (head_valid_reg && !pop_ready);
  assign pop_data   = head_reg;
  assign pop_valid  = head_valid_reg;

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr_reg] <= push_data;
    else if (retag_mem)
      mem[newest_ptr] <= {1'b1, newest_reg[WIDTH-2:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      newest_reg     <= '0;
      head_reg       <= '0;
      head_valid_reg <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
        newest_reg <= push_data;
      end else if (retag_mem) begin
        newest_reg[WIDTH-1] <= 1'b1;
      end
      if (mem_pop) begin
        rd_ptr_reg     <= rd_ptr_reg + PTR_ONE;
        head_valid_reg <= 1'b1;
        // The sole memory entry leaving as it is retagged bypasses the stale read.
        if (retag_mem && count_reg == CNT_ONE)
          head_reg <= {1'b1, mem[rd_ptr_reg][WIDTH-2:0]};
        else
          head_reg <= mem[rd_ptr_reg];
      end else begin
        if (pop_ready)
          head_valid_reg <= 1'b0;
        if (retag && count_reg == '0 && head_valid_reg && !pop_ready)
          head_reg[WIDTH-1] <= 1'b1;
      end
      case ({do_push, mem_pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/bitstream_expander.sv
// Expands entropy-coder packets (direct bytes, byte runs, tails) into a framed byte stream.
module bitstream_expander
  import bitstream_expander_pkg::*;
#(
  parameter int BS_WIDTH   = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 top_clk,
  input  logic                 top_reset,
  bitstream_expander_if.slave  bus,
  output logic                 out_done,
  output logic [CNT_WIDTH-1:0] out_byte_count,
  output logic                 out_error
);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [BS_WIDTH-1:0]  RUN_ONE = 1;

  state_e               state_reg, state_next;
  logic                 alive_reg;
  logic [BS_WIDTH-1:0]  in_bits [5];
  logic [BS_WIDTH-1:0]  pkt_bits_reg [5];
  logic [2:0]           pkt_flag_reg;
  logic                 pkt_last_reg;
  logic [BS_WIDTH-1:0]  run_cnt_reg, run_cnt_next;
  logic                 dir_sel_reg, dir_sel_next;
  logic                 wait_done_reg, done_reg, error_reg;
  logic [CNT_WIDTH-1:0] count_reg;
  logic                 push;
  logic [BS_WIDTH-1:0]  push_byte;
  logic [BS_WIDTH:0]    fifo_data;
  logic                 fifo_full, fifo_pending, fifo_valid, out_last_w;
  logic                 accept, zero_last, zero_last_empty, xfer, done_set;

  assign in_bits[0] = bus.in_bit_1;
  assign in_bits[1] = bus.in_bit_2;
  assign in_bits[2] = bus.in_bit_3;
  assign in_bits[3] = bus.in_bit_4;
  assign in_bits[4] = bus.in_bit_5;

  assign bus.in_ready    = alive_reg && (state_reg == ST_IDLE) && !wait_done_reg;
  assign accept          = bus.in_valid && bus.in_ready;
  assign zero_last       = accept && bus.in_flag_last && (bus.in_flag_bitstream == FLAG_NONE);
  assign zero_last_empty = zero_last && !fifo_pending;
  assign out_last_w      = fifo_valid && fifo_data[BS_WIDTH];
  assign xfer            = fifo_valid && bus.out_ready;
  assign done_set        = (xfer && out_last_w) || zero_last_empty;

  assign bus.out_byte    = fifo_data[BS_WIDTH-1:0];
  assign bus.out_valid   = fifo_valid;
  assign bus.out_last    = out_last_w;
  assign out_done        = done_reg;
  assign out_byte_count  = count_reg;
  assign out_error       = error_reg;

  for (genvar gi = 0; gi < 5; gi++) begin : g_pkt
    always_ff @(posedge top_clk or negedge top_reset) begin
      if (!top_reset)
        pkt_bits_reg[gi] <= '0;
      else if (accept)
        pkt_bits_reg[gi] <= in_bits[gi];
    end
  end

  // Every non-idle state writes one byte; all progress stalls while the FIFO is full.
  always_comb begin
    state_next   = state_reg;
    run_cnt_next = run_cnt_reg;
    dir_sel_next = dir_sel_reg;
    push         = 1'b0;
    push_byte    = '0;
    case (state_reg)
      ST_IDLE: begin
        if (accept && flag_emits(bus.in_flag_bitstream))
          state_next = ST_HEAD;
        if (accept) begin
          run_cnt_next = bus.in_bit_3;
          dir_sel_next = 1'b0;
        end
      end
      ST_HEAD: begin
        push      = 1'b1;
        push_byte = pkt_bits_reg[0];
        if (!fifo_full) begin
          if (pkt_flag_reg == 3'd2 || pkt_flag_reg == 3'd3)
            state_next = ST_DIRECT;
          else if (pkt_flag_reg >= FLAG_RUN && run_cnt_reg != '0)
            state_next = ST_RUN;
          else if (pkt_flag_reg >= FLAG_RUN_B4)
            state_next = ST_TAIL4;
          else
            state_next = ST_IDLE;
        end
      end
      ST_DIRECT: begin
        push      = 1'b1;
        push_byte = dir_sel_reg ? pkt_bits_reg[2] : pkt_bits_reg[1];
        if (!fifo_full) begin
          if (dir_sel_reg || pkt_flag_reg == 3'd2)
            state_next = ST_IDLE;
          else
            dir_sel_next = 1'b1;
        end
      end
      ST_RUN: begin
        push      = 1'b1;
        push_byte = pkt_bits_reg[1];
        if (!fifo_full) begin
          run_cnt_next = run_cnt_reg - RUN_ONE;
          if (run_cnt_reg == RUN_ONE)
            state_next = (pkt_flag_reg == FLAG_RUN) ? ST_IDLE : ST_TAIL4;
        end
      end
      ST_TAIL4: begin
        push      = 1'b1;
        push_byte = pkt_bits_reg[3];
        if (!fifo_full)
          state_next = (pkt_flag_reg == FLAG_RUN_B5) ? ST_TAIL5 : ST_IDLE;
      end
      ST_TAIL5: begin
        push      = 1'b1;
        push_byte = pkt_bits_reg[4];
        if (!fifo_full)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge top_clk or negedge top_reset) begin
    if (!top_reset) begin
      alive_reg     <= 1'b0;
      state_reg     <= ST_IDLE;
      run_cnt_reg   <= '0;
      dir_sel_reg   <= 1'b0;
      pkt_flag_reg  <= FLAG_NONE;
      pkt_last_reg  <= 1'b0;
      wait_done_reg <= 1'b0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
      count_reg     <= '0;
    end else begin
      alive_reg   <= 1'b1;
      state_reg   <= state_next;
      run_cnt_reg <= run_cnt_next;
      dir_sel_reg <= dir_sel_next;
      if (accept) begin
        pkt_flag_reg <= bus.in_flag_bitstream;
        pkt_last_reg <= bus.in_flag_last;
      end
      if (accept && bus.in_flag_bitstream == FLAG_ILLEGAL)
        error_reg <= 1'b1;
      // Illegal packets are dropped whole, so they never close a frame.
      if (accept && bus.in_flag_last && bus.in_flag_bitstream != FLAG_ILLEGAL && !zero_last_empty)
        wait_done_reg <= 1'b1;
      else if (done_set)
        wait_done_reg <= 1'b0;
      done_reg <= done_set;
      if (done_set)
        count_reg <= '0;
      else if (xfer)
        count_reg <= count_reg + CNT_ONE;
    end
  end

  bitstream_fifo #(
    .WIDTH (BS_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (top_clk),
    .rst_n     (top_reset),
    .push      (push),
    .push_data ({pkt_last_reg && (state_next == ST_IDLE), push_byte}),
    .full      (fifo_full),
    .retag     (zero_last),
    .pending   (fifo_pending),
    .pop_data  (fifo_data),
    .pop_valid (fifo_valid),
    .pop_ready (bus.out_ready)
  );
endmodule

// File: tb/tb_bitstream_expander.sv
// Directed self-checking bench for bitstream_expander with a negedge transfer monitor.
module tb_bitstream_expander;
  logic        top_clk = 1'b0;
  logic        top_reset = 1'b0;
  logic        out_done;
  logic [31:0] out_byte_count;
  logic        out_error;

  bitstream_expander_if #(.BS_WIDTH(8)) bus ();

  bitstream_expander #(.BS_WIDTH(8), .FIFO_DEPTH(16), .CNT_WIDTH(32)) dut (
    .top_clk        (top_clk),
    .top_reset      (top_reset),
    .bus            (bus),
    .out_done       (out_done),
    .out_byte_count (out_byte_count),
    .out_error      (out_error)
  );

  always #5 top_clk = ~top_clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] q_byte [$];
  logic       q_last [$];
  int cyc = 0;
  int done_cnt = 0;
  int xfer_cyc = 0;
  int done_cyc = 0;
  int rdy_high = 0;
  logic watch_rdy = 1'b0;

  logic [7:0] exp2 [7] = '{8'hA0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h02};

  // Transfers happen at the next posedge; inputs are stable at the negedge.
  always @(negedge top_clk) begin
    cyc <= cyc + 1;
    if (bus.out_valid && bus.out_ready) begin
      q_byte.push_back(bus.out_byte);
      q_last.push_back(bus.out_last);
      xfer_cyc <= cyc;
    end
    if (out_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (watch_rdy && bus.in_ready && !out_done)
      rdy_high <= rdy_high + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge top_clk);
    #1;
  endtask

  task automatic send(input logic [2:0] flag, input logic [7:0] b1, input logic [7:0] b2,
                      input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                      input logic last);
    int n;
    n = 0;
    bus.in_flag_bitstream = flag;
    bus.in_bit_1 = b1;
    bus.in_bit_2 = b2;
    bus.in_bit_3 = b3;
    bus.in_bit_4 = b4;
    bus.in_bit_5 = b5;
    bus.in_flag_last = last;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin
      tick();
      n++;
    end
    check("send_ready", 32'(n < 100), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int start;
    int bad;
    int tags;
    bus.in_valid = 1'b0;
    bus.in_bit_1 = '0;
    bus.in_bit_2 = '0;
    bus.in_bit_3 = '0;
    bus.in_bit_4 = '0;
    bus.in_bit_5 = '0;
    bus.in_flag_bitstream = '0;
    bus.in_flag_last = 1'b0;
    bus.out_ready = 1'b1;

    // Reset values while asserted
    tick(); tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_out_done", 32'(out_done), 32'd0);
    check("rst_out_byte", 32'(bus.out_byte), 32'd0);
    check("rst_count", out_byte_count, 32'd0);
    check("rst_error", 32'(out_error), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    top_reset = 1'b1;
    @(negedge top_clk);
    check("rel_in_ready_low", 32'(bus.in_ready), 32'd0);
    tick();
    check("rel_in_ready_high", 32'(bus.in_ready), 32'd1);

    // Flag 3 latency and ordering
    send(3'd3, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 1'b0);
    check("t1_busy", 32'(bus.in_ready), 32'd0);
    check("t1_edge0_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("t1_edge1_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("t1_edge2_valid", 32'(bus.out_valid), 32'd1);
    check("t1_byte0", 32'(bus.out_byte), 32'h11);
    tick();
    check("t1_byte1", 32'(bus.out_byte), 32'h22);
    tick();
    check("t1_byte2", 32'(bus.out_byte), 32'h33);
    check("t1_byte2_last", 32'(bus.out_last), 32'd0);
    tick();
    check("t1_drained", 32'(bus.out_valid), 32'd0);
    check("t1_count", out_byte_count, 32'd3);

    // Zero-byte last packet on an empty FIFO
    send(3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    check("t1b_done", 32'(out_done), 32'd1);
    check("t1b_count", out_byte_count, 32'd0);
    check("t1b_last", 32'(bus.out_last), 32'd0);
    tick();
    check("t1b_done_pulse", 32'(out_done), 32'd0);

    // Flag 7 run with two tails
    base = q_byte.size();
    send(3'd7, 8'hA0, 8'hFF, 8'h04, 8'h01, 8'h02, 1'b0);
    for (int i = 0; i < 40 && q_byte.size() < base + 7; i++) tick();
    tick(); tick();
    check("t2_nbytes", 32'(q_byte.size() - base), 32'd7);
    bad = 0;
    for (int i = 0; i < 7; i++)
      if (base + i >= q_byte.size() || q_byte[base+i] !== exp2[i]) bad++;
    check("t2_bytes_bad", 32'(bad), 32'd0);
    check("t2_count", out_byte_count, 32'd7);

    // Retag of a pending entry by a zero-byte last packet
    bus.out_ready = 1'b0;
    base = q_byte.size();
    start = done_cnt;
    send(3'd1, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    send(3'd1, 8'h6B, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tick(); tick();
    send(3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    check("t3_wait_ready", 32'(bus.in_ready), 32'd0);
    check("t3_no_done", 32'(out_done), 32'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && done_cnt == start; i++) tick();
    check("t3_done_seen", 32'(done_cnt - start), 32'd1);
    check("t3_nbytes", 32'(q_byte.size() - base), 32'd2);
    check("t3_b0", 32'(q_byte[base]), 32'h5A);
    check("t3_b0_last", 32'(q_last[base]), 32'd0);
    check("t3_b1", 32'(q_byte[base+1]), 32'h6B);
    check("t3_b1_last", 32'(q_last[base+1]), 32'd1);
    check("t3_count", out_byte_count, 32'd0);

    // Flag 5, zero repeats, last
    base = q_byte.size();
    start = done_cnt;
    send(3'd5, 8'h3C, 8'h99, 8'h00, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 20 && done_cnt == start; i++) tick();
    check("t4_done_seen", 32'(done_cnt - start), 32'd1);
    check("t4_nbytes", 32'(q_byte.size() - base), 32'd1);
    check("t4_byte", 32'(q_byte[base]), 32'h3C);
    check("t4_last", 32'(q_last[base]), 32'd1);
    check("t4_done_delay", 32'(done_cyc - xfer_cyc), 32'd1);
    check("t4_count", out_byte_count, 32'd0);

    // Flag 6 with 255 repeats under 50% backpressure
    base = q_byte.size();
    start = done_cnt;
    send(3'd6, 8'h10, 8'h77, 8'hFF, 8'h99, 8'h00, 1'b1);
    watch_rdy = 1'b1;
    for (int i = 0; i < 3000 && done_cnt == start; i++) begin
      bus.out_ready = ~bus.out_ready;
      tick();
    end
    watch_rdy = 1'b0;
    bus.out_ready = 1'b1;
    check("t5_done_seen", 32'(done_cnt - start), 32'd1);
    check("t5_nbytes", 32'(q_byte.size() - base), 32'd257);
    bad = 0;
    tags = 0;
    for (int i = 0; i < 257 && base + i < q_byte.size(); i++) begin
      if (q_byte[base+i] !== ((i == 0) ? 8'h10 : (i == 256) ? 8'h99 : 8'h77)) bad++;
      if (q_last[base+i]) tags++;
    end
    check("t5_bytes_bad", 32'(bad), 32'd0);
    check("t5_last_tags", 32'(tags), 32'd1);
    check("t5_final_last", 32'(q_last[q_last.size()-1]), 32'd1);
    check("t5_in_ready_high", 32'(rdy_high), 32'd0);

    // Illegal flag then a flag 2 packet
    base = q_byte.size();
    send(3'd4, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    check("t6_no_output", 32'(q_byte.size() - base), 32'd0);
    check("t6_error", 32'(out_error), 32'd1);
    check("t6_ready", 32'(bus.in_ready), 32'd1);
    send(3'd2, 8'h21, 8'h42, 8'h00, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 20 && q_byte.size() < base + 2; i++) tick();
    tick();
    check("t6_nbytes", 32'(q_byte.size() - base), 32'd2);
    check("t6_b0", 32'(q_byte[base]), 32'h21);
    check("t6_b1", 32'(q_byte[base+1]), 32'h42);
    check("t6_error_held", 32'(out_error), 32'd1);
    check("t6_count", out_byte_count, 32'd2);

    // Reset in the middle of a 200-byte run
    send(3'd5, 8'h01, 8'h02, 8'hC8, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    check("t7_running", 32'(bus.out_valid), 32'd1);
    top_reset = 1'b0;
    #1;
    check("t7_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t7_rst_count", out_byte_count, 32'd0);
    check("t7_rst_ready", 32'(bus.in_ready), 32'd0);
    check("t7_rst_error", 32'(out_error), 32'd0);
    tick(); tick();
    top_reset = 1'b1;
    tick();
    check("t7_rel_ready", 32'(bus.in_ready), 32'd1);
    base = q_byte.size();
    for (int i = 0; i < 5; i++) tick();
    check("t7_no_stale", 32'(q_byte.size() - base), 32'd0);
    check("t7_idle_valid", 32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
